// File: rtl/pipe_stage_buf.sv
// Width-generic valid/ready pipeline stage with flush-to-bubble and a saturating stall counter.
// Define PIPE_SKID_EN to add a one-entry skid register that makes in_ready a register output.
module pipe_stage_buf #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_flush,
  input  logic              stage_flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              flush;
  logic              accept;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  assign flush = exc_flush | stage_flush;

  // Stall counter: sees the pre-flush valid, so flush cycles still count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (reset)
      stall_cnt_d = '0;
    else if (main_valid_q && !out_ready)
      stall_cnt_d = sat_inc(stall_cnt_q);
  end

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (reset || flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE_VAL;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-main move can happen.
      if (out_ready) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q && !out_ready) begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    skid_valid_q <= skid_valid_d;
    skid_data_q  <= skid_data_d;
  end
`else
  assign in_ready = ~main_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (reset || flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE_VAL;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    main_valid_q <= main_valid_d;
    main_data_q  <= main_data_d;
    stall_cnt_q  <= stall_cnt_d;
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf; a second CNT_W=4 instance exercises counter saturation.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset, exc_flush, stage_flush, in_valid, out_ready, out_ready2;
  logic [95:0] in_data;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [95:0] out_data, out_data2;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt2;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(96), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .exc_flush(exc_flush), .stage_flush(stage_flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .stall_cnt(stall_cnt));

  pipe_stage_buf #(.DATA_W(96), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .exc_flush(exc_flush), .stage_flush(stage_flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .stall_cnt(stall_cnt2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; exc_flush = 1'b0; stage_flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; out_ready2 = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 96'h0) begin n_err++; $display("FAIL rst_data got=%h exp=0", out_data); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 96'h123 + 96'(i);
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      n_cmp++; if (out_data !== 96'h123 + 96'(i)) begin n_err++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, 96'h123 + 96'(i)); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 96'h126) begin n_err++; $display("FAIL drain_hold got=%h exp=126", out_data); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stream_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_stall;
    do_reset();
    in_valid = 1'b1; in_data = 96'hA;
    tick();
    out_ready = 1'b0; in_data = 96'hB;
    for (int k = 1; k <= 5; k++) begin
      tick();
`ifdef PIPE_SKID_EN
      in_valid = 1'b0;
`endif
      n_cmp++; if (out_data !== 96'hA || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/a", k, out_valid, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", k, in_ready); end
      n_cmp++; if (stall_cnt !== 16'(k)) begin n_err++; $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", k, stall_cnt, k); end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 96'hB || out_valid !== 1'b1) begin n_err++; $display("FAIL release_b got=%b/%h exp=1/b", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_empty got=%b exp=0", out_valid); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL release_cnt got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_stage_flush;
    do_reset();
    in_valid = 1'b1; in_data = 96'hBEEF;
    tick();
    stage_flush = 1'b1; in_data = 96'hDEAD; out_ready = 1'b0;
    tick();
    stage_flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sflush_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 96'h0) begin n_err++; $display("FAIL sflush_data got=%h exp=0", out_data); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL sflush_cnt got=%0d exp=1", stall_cnt); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sflush_no_dead got=%b exp=0", out_valid); end
  endtask

  task automatic test_exc_flush;
    do_reset();
    in_valid = 1'b1; in_data = 96'h11;
    tick();
    out_ready = 1'b0; in_data = 96'h22;
    tick();
    in_valid = 1'b0; exc_flush = 1'b1; stage_flush = 1'b1;
    tick();
    exc_flush = 1'b0; stage_flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL eflush_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL eflush_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL eflush_cnt got=%0d exp=2", stall_cnt); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL eflush_skid_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturate;
    do_reset();
    in_valid = 1'b1; in_data = 96'h55;
    tick();
    in_valid = 1'b0; out_ready2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15 || k == 20) begin
        n_cmp++; if (stall_cnt2 !== ((k > 15) ? 4'd15 : 4'(k))) begin n_err++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, stall_cnt2, (k > 15) ? 15 : k); end
      end
    end
    n_cmp++; if (out_data2 !== 96'h55 || out_valid2 !== 1'b1) begin n_err++; $display("FAIL sat_hold got=%b/%h exp=1/55", out_valid2, out_data2); end
    out_ready2 = 1'b1;
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    in_valid = 1'b1; in_data = 96'h33;
    tick();
    out_ready = 1'b0; in_data = 96'h44;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got=%b exp=0", out_valid); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL mrst_cnt got=%0d exp=0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_data !== 96'h0) begin n_err++; $display("FAIL mrst_data got=%h exp=0", out_data); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_skid_drop got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_stage_flush();
    test_exc_flush();
    test_saturate();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
